// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the load/store access controller: word-size codes and FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mem_access_ctrl_pkg;

    localparam logic [2:0] BYTE_WORD     = 3'd0;
    localparam logic [2:0] HALF_WORD     = 3'd1;
    localparam logic [2:0] COMPLETE_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Places store data/byte enables on memory lanes and extracts/extends load data.
// Latency: purely combinational.
// Backpressure: none; follows whatever the controller latched.
module mem_lane_align
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int TYPE      = 3,
    parameter int LANES     = DATA_SIZE / 8,
    parameter int OFS       = $clog2(LANES)
) (
    input  logic [TYPE-1:0]      i_word_size,
    input  logic [OFS-1:0]       i_offset,
    input  logic                 i_signed,
    input  logic [DATA_SIZE-1:0] i_wdata,
    input  logic [DATA_SIZE-1:0] i_rdata,
    output logic [LANES-1:0]     o_be,
    output logic [DATA_SIZE-1:0] o_wdata,
    output logic [DATA_SIZE-1:0] o_rdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [OFS-1:0] half_ofs;

    // Halfword lane index ignores offset bit 0 so the select never runs off the top of the word.
    assign half_ofs = {i_offset[OFS-1:1], 1'b0};

    // Store side: replicate narrow data across every lane and enable only the addressed bytes.
    always_comb begin
        o_be    = '1;
        o_wdata = i_wdata;
        case (i_word_size)
            BYTE_WORD: begin
                o_be    = LANES'(1) << i_offset;
                o_wdata = {LANES{i_wdata[7:0]}};
            end
            HALF_WORD: begin
                o_be    = LANES'(3) << i_offset;
                o_wdata = {(LANES/2){i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed lane out of the full word, then sign- or zero-extend.
    always_comb begin
        byte_v  = i_rdata[8*i_offset +: 8];
        half_v  = i_rdata[8*half_ofs +: 16];
        o_rdata = i_rdata;
        case (i_word_size)
            BYTE_WORD: o_rdata = {{(DATA_SIZE-8){i_signed & byte_v[7]}}, byte_v};
            HALF_WORD: o_rdata = {{(DATA_SIZE-16){i_signed & half_v[15]}}, half_v};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Pipeline-to-memory load/store controller: alignment check, request handshake, timeout.
// Latency: accept to DONE is 1 + number of REQ cycles (minimum 2); faults take 1 cycle.
// Backpressure: o_stall holds the pipeline during accept and REQ; requests outside IDLE are ignored.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 32,
    parameter int TYPE      = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_read,
    input  logic                        i_write,
    input  logic                        i_signed,
    input  logic [TYPE-1:0]             i_word_size,
    input  logic [ADDR_SIZE-1:0]        i_addr,
    input  logic [DATA_SIZE-1:0]        i_write_data,
    output logic [DATA_SIZE-1:0]        o_read_data,
    output logic                        o_stall,
    output logic                        o_misaligned,
    output logic                        o_timeout,
    output logic                        o_mem_req,
    output logic                        o_mem_we,
    output logic [ADDR_SIZE-1:0]        o_mem_addr,
    output logic [DATA_SIZE/8-1:0]      o_mem_be,
    output logic [DATA_SIZE-1:0]        o_mem_wdata,
    input  logic                        i_mem_ack,
    input  logic [DATA_SIZE-1:0]        i_mem_rdata
);

    localparam int LANES = DATA_SIZE / 8;
    localparam int OFS   = $clog2(LANES);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic                   signed_q, signed_d;
    logic                   to_q, to_d;
    logic [TYPE-1:0]        size_q, size_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [DATA_SIZE-1:0]   wdata_q, wdata_d;
    logic [DATA_SIZE-1:0]   rdata_q, rdata_d;

    logic                   start;
    logic                   size_legal;
    logic                   aligned;
    logic [LANES-1:0]       lane_be;
    logic [DATA_SIZE-1:0]   lane_wdata;
    logic [DATA_SIZE-1:0]   lane_rdata;

    mem_lane_align #(
        .DATA_SIZE (DATA_SIZE),
        .TYPE      (TYPE)
    ) u_lane (
        .i_word_size (size_q),
        .i_offset    (addr_q[OFS-1:0]),
        .i_signed    (signed_q),
        .i_wdata     (wdata_q),
        .i_rdata     (i_mem_rdata),
        .o_be        (lane_be),
        .o_wdata     (lane_wdata),
        .o_rdata     (lane_rdata)
    );

    // Classify the incoming request; start is gated by reset so nothing is accepted while held.
    always_comb begin
        start      = i_rst_n && (state_q == ST_IDLE) && (i_read || i_write);
        size_legal = (i_word_size == BYTE_WORD) || (i_word_size == HALF_WORD) ||
                     (i_word_size == COMPLETE_WORD);
        aligned    = 1'b1;
        if (i_word_size == HALF_WORD)     aligned = !i_addr[0];
        if (i_word_size == COMPLETE_WORD) aligned = (i_addr[OFS-1:0] == '0);
    end

    // Next-state logic: accept/fault from IDLE, wait for ack or timeout in REQ, single-cycle DONE/FAULT.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        signed_d = signed_q;
        to_d     = to_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (size_legal && aligned) begin
                        we_d     = i_write;
                        signed_d = i_signed;
                        size_d   = i_word_size;
                        addr_d   = i_addr;
                        wdata_d  = i_write_data;
                        cnt_d    = '0;
                        state_d  = ST_REQ;
                    end else begin
                        to_d    = 1'b0;
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_REQ: begin
                if (i_mem_ack) begin
                    if (!we_q) rdata_d = lane_rdata;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and latched-request registers; reset clears everything mid-transaction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            to_q     <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            signed_q <= signed_d;
            to_q     <= to_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Outputs: memory side only driven in REQ so it reads as zero whenever idle or in reset.
    always_comb begin
        o_stall      = (state_q == ST_REQ) || (start && size_legal && aligned);
        o_mem_req    = (state_q == ST_REQ);
        o_mem_we     = o_mem_req && we_q;
        o_mem_addr   = o_mem_req ? {addr_q[ADDR_SIZE-1:OFS], {OFS{1'b0}}} : '0;
        o_mem_be     = o_mem_req ? lane_be : '0;
        o_mem_wdata  = o_mem_req ? lane_wdata : '0;
        o_misaligned = (state_q == ST_FAULT) && !to_q;
        o_timeout    = (state_q == ST_FAULT) && to_q;
        o_read_data  = rdata_q;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, stores, faults, timeout and mid-transaction reset.
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns after it.
// Every wait is a fixed number of cycles, so the run always terminates.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_read;
    logic        i_write;
    logic        i_signed;
    logic [2:0]  i_word_size;
    logic [31:0] i_addr;
    logic [31:0] i_write_data;
    logic [31:0] o_read_data;
    logic        o_stall;
    logic        o_misaligned;
    logic        o_timeout;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_read       (i_read),
        .i_write      (i_write),
        .i_signed     (i_signed),
        .i_word_size  (i_word_size),
        .i_addr       (i_addr),
        .i_write_data (i_write_data),
        .o_read_data  (o_read_data),
        .o_stall      (o_stall),
        .o_misaligned (o_misaligned),
        .o_timeout    (o_timeout),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_be     (o_mem_be),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_read       = 1'b0;
        i_write      = 1'b0;
        i_signed     = 1'b0;
        i_word_size  = BYTE_WORD;
        i_addr       = '0;
        i_write_data = '0;
        i_mem_ack    = 1'b0;
        i_mem_rdata  = '0;

        // Reset state
        #12;
        chk("rst_req", o_mem_req, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_rdata", o_read_data, 0);
        chk("rst_mis", o_misaligned, 0);
        chk("rst_to", o_timeout, 0);
        chk("rst_addr", o_mem_addr, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Signed byte load at offset 3, ack in the second REQ cycle: stall for 3 cycles
        step();
        i_read = 1; i_signed = 1; i_word_size = BYTE_WORD; i_addr = 32'h0000_1003;
        #1;
        chk("s1_stall_c1", o_stall, 1);
        chk("s1_noreq_c1", o_mem_req, 0);
        step();
        i_read = 0; i_signed = 0;
        #1;
        chk("s1_req", o_mem_req, 1);
        chk("s1_addr", o_mem_addr, 32'h0000_1000);
        chk("s1_we", o_mem_we, 0);
        chk("s1_stall_c2", o_stall, 1);
        step();
        i_mem_ack = 1; i_mem_rdata = 32'h8011_2233;
        #1;
        chk("s1_stall_c3", o_stall, 1);
        chk("s1_req_c3", o_mem_req, 1);
        step();
        i_mem_ack = 0;
        #1;
        chk("s1_done_stall", o_stall, 0);
        chk("s1_done_req", o_mem_req, 0);
        chk("s1_rdata", o_read_data, 32'hFFFF_FF80);
        step();
        #1;
        chk("s1_rdata_hold", o_read_data, 32'hFFFF_FF80);

        // Unsigned half load at offset 2, ack immediately
        i_read = 1; i_word_size = HALF_WORD; i_addr = 32'h0000_2002;
        i_mem_ack = 1; i_mem_rdata = 32'h8001_7FFF;
        #1;
        chk("s2_stall", o_stall, 1);
        step();
        i_read = 0;
        #1;
        chk("s2_req", o_mem_req, 1);
        step();
        i_mem_ack = 0;
        #1;
        chk("s2_rdata", o_read_data, 32'h0000_8001);
        chk("s2_done_stall", o_stall, 0);

        // Byte store at offset 1 with read also high: write wins
        step();
        i_read = 1; i_write = 1; i_word_size = BYTE_WORD; i_addr = 32'h0000_0001;
        i_write_data = 32'h0000_00AB;
        #1;
        chk("s3_stall", o_stall, 1);
        step();
        i_read = 0; i_write = 0; i_write_data = '0;
        #1;
        chk("s3_we", o_mem_we, 1);
        chk("s3_wdata", o_mem_wdata, 32'hABAB_ABAB);
        chk("s3_be", o_mem_be, 4'b0010);
        chk("s3_addr", o_mem_addr, 32'h0);
        i_mem_ack = 1;
        step();
        i_mem_ack = 0;
        #1;
        chk("s3_rdata_kept", o_read_data, 32'h0000_8001);
        chk("s3_done_stall", o_stall, 0);

        // Half store at offset 2
        step();
        i_write = 1; i_word_size = HALF_WORD; i_addr = 32'h0000_0022; i_write_data = 32'h0000_1234;
        step();
        i_write = 0;
        #1;
        chk("s3b_wdata", o_mem_wdata, 32'h1234_1234);
        chk("s3b_be", o_mem_be, 4'b1100);
        chk("s3b_addr", o_mem_addr, 32'h0000_0020);
        i_mem_ack = 1;
        step();
        i_mem_ack = 0;

        // Misaligned full-word load
        step();
        i_read = 1; i_word_size = COMPLETE_WORD; i_addr = 32'h0000_0002;
        #1;
        chk("s4_stall", o_stall, 0);
        chk("s4_req", o_mem_req, 0);
        step();
        i_read = 0;
        #1;
        chk("s4_mis", o_misaligned, 1);
        chk("s4_to", o_timeout, 0);
        chk("s4_req_f", o_mem_req, 0);
        chk("s4_stall_f", o_stall, 0);
        step();
        #1;
        chk("s4_mis_end", o_misaligned, 0);

        // Undefined size code
        i_read = 1; i_word_size = 3'd5; i_addr = 32'h0;
        #1;
        chk("s4b_stall", o_stall, 0);
        step();
        i_read = 0; i_word_size = BYTE_WORD;
        #1;
        chk("s4b_mis", o_misaligned, 1);
        chk("s4b_req", o_mem_req, 0);
        step();

        // Timeout: request held exactly 16 cycles, then a one-cycle timeout pulse
        i_read = 1; i_word_size = COMPLETE_WORD; i_addr = 32'h0000_0040;
        step();
        i_read = 0;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk("s5_req_held", o_mem_req, 1);
            step();
        end
        #1;
        chk("s5_req_drop", o_mem_req, 0);
        chk("s5_to", o_timeout, 1);
        chk("s5_mis", o_misaligned, 0);
        chk("s5_stall", o_stall, 0);
        i_mem_ack = 1; i_mem_rdata = 32'hFFFF_FFFF;
        step();
        #1;
        chk("s5_to_end", o_timeout, 0);
        chk("s5_ack_ignored", o_read_data, 32'h0000_8001);
        i_mem_ack = 0;

        // Reset during REQ, then a fresh signed half load
        i_read = 1; i_word_size = BYTE_WORD; i_addr = 32'h0;
        step();
        i_read = 0;
        #1;
        chk("s6_req", o_mem_req, 1);
        i_rst_n = 0;
        #1;
        chk("s6_rst_req", o_mem_req, 0);
        chk("s6_rst_stall", o_stall, 0);
        chk("s6_rst_rdata", o_read_data, 0);
        @(negedge i_clk);
        i_rst_n = 1;
        step();
        i_read = 1; i_signed = 1; i_word_size = HALF_WORD; i_addr = 32'h0000_0100;
        i_mem_ack = 1; i_mem_rdata = 32'h1234_8000;
        #1;
        chk("s6_stall", o_stall, 1);
        step();
        i_read = 0; i_signed = 0;
        #1;
        chk("s6_req2", o_mem_req, 1);
        step();
        i_mem_ack = 0;
        #1;
        chk("s6_rdata", o_read_data, 32'hFFFF_8000);
        chk("s6_done_stall", o_stall, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_SIZE 32, data width (multiple of 8, power of two); ADDR_SIZE 32, byte-address width; TYPE 3, word-size code width; TIMEOUT 16, max cycles waiting for ack.
REQ-002 Derived: LANES = DATA_SIZE/8; OFS = log2(LANES).
REQ-003 One clock; reset is asynchronous and active-low: i_clk, i_rst_n.
REQ-004 Pipeline-side ports SHALL be:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_read  in  1  load request
- i_write  in  1  store request
- i_signed  in  1  sign-extend load
- i_word_size  in  TYPE  BYTE_WORD/HALF_WORD/COMPLETE_WORD
- i_addr  in  ADDR_SIZE  byte address
- i_write_data  in  DATA_SIZE  store data, right-aligned
- o_read_data  out  DATA_SIZE  extended load result
- o_stall  out  1  freeze pipeline
- o_misaligned  out  1  one-cycle fault pulse
- o_timeout  out  1  one-cycle fault pulse
REQ-005 Memory-side ports SHALL be:
- o_mem_req  out  1  request
- o_mem_we  out  1  write
- o_mem_addr  out  ADDR_SIZE  address, low OFS bits zero
- o_mem_be  out  LANES  byte enables
- o_mem_wdata  out  DATA_SIZE  lane-placed store data
- i_mem_ack  in  1  completion
- i_mem_rdata  in  DATA_SIZE  full-word read data

Function
REQ-006 FSM states SHALL be IDLE, REQ, DONE, FAULT.
REQ-007 IDLE, i_read|i_write, aligned, legal size: latch op/addr/size/signed/data; go REQ; o_stall high combinationally that cycle.
- Both i_read and i_write high: write wins.
REQ-008 Alignment rule SHALL be: HALF needs addr[0]=0; COMPLETE needs addr[OFS-1:0]=0; BYTE is always aligned.
REQ-009 Misaligned access or undefined size code in IDLE SHALL: issue no memory request, go FAULT, keep o_stall low.
REQ-010 REQ SHALL drive o_mem_req=1 from the latched request and hold all memory outputs stable until the i_mem_ack cycle.
REQ-011 Store lanes: BYTE data replicated to every lane, be = 1<<addr[OFS-1:0]; HALF data replicated per halfword, be = 2'b11<<addr[OFS-1:0]; COMPLETE be = all ones.
REQ-012 On i_mem_ack in REQ: register the extracted load value (lane selected by latched offset, sign- or zero-extended per latched i_signed); go DONE.
REQ-013 DONE SHALL last exactly 1 cycle with o_stall=0 and o_read_data valid, then return to IDLE; o_read_data holds its value until the next load completes.
REQ-014 Store-complete o_read_data SHALL be left unchanged.
REQ-015 Minimum latency, accept to DONE, SHALL be 2 cycles (ack in first REQ cycle).
REQ-016 A cycle counter SHALL run in REQ; ack not seen within TIMEOUT cycles: drop o_mem_req, go FAULT.
REQ-017 FAULT SHALL last 1 cycle with o_stall=0, then go IDLE.
- o_misaligned=1 if entered from IDLE.
- o_timeout=1 if entered from REQ.
REQ-018 i_mem_ack outside REQ SHALL be ignored.
REQ-019 New requests while not IDLE SHALL be ignored; the pipeline is stalled.

Reset
REQ-020 i_rst_n low SHALL asynchronously force IDLE, counter 0, and all outputs 0, including mid-transaction (o_mem_req falls immediately).
REQ-021 After release, the first accept SHALL occur no earlier than the first rising edge with i_rst_n high.

Structure
REQ-022 BYTE_WORD/HALF_WORD/COMPLETE_WORD codes and FSM state encodings SHALL live in the shared parameters header.
REQ-023 Lane placement/extraction plus extension SHALL be one combinational sub-module, mem_lane_align; the FSM, counter and latches SHALL stay in mem_access_ctrl.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Signed BYTE load, addr 0x...03, rdata 0x80112233, ack after 2 cycles -> o_read_data 0xFFFFFF80, o_stall high 3 cycles.
- Unsigned HALF load, addr 0x...02, rdata 0x8001_7FFF, ack immediate -> o_read_data 0x00008001.
- BYTE store 0x000000AB, addr 0x...01 -> o_mem_wdata 0xABABABAB, o_mem_be 4'b0010, o_mem_we 1.
- COMPLETE load, addr 0x...02 -> o_misaligned pulse, no o_mem_req, o_stall never high.
- No ack for TIMEOUT=16 cycles -> o_mem_req drops, o_timeout 1-cycle pulse, IDLE next.
- i_rst_n low during REQ -> o_mem_req and o_stall 0 immediately; a fresh load after release completes normally.
